// File: rtl/demosaic_scan_ctrl_if.sv
// Handshake/bus bundle between the demosaic frame sequencer and the filter/output store.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface demosaic_scan_ctrl_if #(
  parameter int XW = 6,
  parameter int YW = 5
);
  logic          start;
  logic          busy;
  logic          done;
  logic          issue_valid;
  logic [XW-1:0] addr_x;
  logic [YW-1:0] addr_y;
  logic [1:0]    lateral;
  logic [1:0]    vertical;
  logic [1:0]    color;
  logic          out_ready;
  logic          wr_en;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;

  modport master (
    input  start, out_ready,
    output busy, done, issue_valid, addr_x, addr_y, lateral, vertical, color,
    output wr_en, wr_x, wr_y
  );

  modport slave (
    output start, out_ready,
    input  busy, done, issue_valid, addr_x, addr_y, lateral, vertical, color,
    input  wr_en, wr_x, wr_y
  );
endinterface

// File: rtl/demosaic_scan_ctrl.sv
// Raster-scan sequencer for the Bayer 3x3 demosaic filter: issues centre-pixel addresses
// with edge/colour classes and delay-matches the write address to the RGBA output store.
module demosaic_scan_ctrl #(
  parameter int WIDTH        = 40,
  parameter int HEIGHT       = 30,
  parameter int PIPE_LATENCY = 1,
  parameter int XW           = 6,
  parameter int YW           = 5
) (
  input  logic                clk,
  input  logic                reset,
  demosaic_scan_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_done;

  logic          r_vld_p [PIPE_LATENCY];
  logic [XW-1:0] r_x_p   [PIPE_LATENCY];
  logic [YW-1:0] r_y_p   [PIPE_LATENCY];

  logic          w_tail_vld;
  logic          w_stall;
  logic          w_wr_en;
  logic          w_last_issue;
  logic          w_last_write;
  logic          w_advance;
  logic          w_launch;
  logic          w_busy;
  logic          w_issue_valid;
  logic [1:0]    w_lateral;
  logic [1:0]    w_vertical;
  logic [1:0]    w_color;

  assign w_tail_vld   = r_vld_p[PIPE_LATENCY-1];
  assign w_stall      = w_tail_vld & ~bus.out_ready;
  assign w_wr_en      = w_tail_vld & bus.out_ready;
  assign w_last_issue = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_last_write = w_wr_en && (r_x_p[PIPE_LATENCY-1] == X_LAST)
                                && (r_y_p[PIPE_LATENCY-1] == Y_LAST);
  assign w_advance    = ~w_stall && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_launch     = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE,
      S_DONE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (!w_stall && w_last_issue) w_next = S_DRAIN;
      S_DRAIN: if (w_last_write) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    w_issue_valid = (r_state == S_RUN);
    w_lateral     = (r_x == '0) ? 2'd0 : ((r_x == X_LAST) ? 2'd2 : 2'd1);
    w_vertical    = (r_y == '0) ? 2'd0 : ((r_y == Y_LAST) ? 2'd2 : 2'd1);
    // Bayer phase {x[0],y[0]} remapped onto the filter's colour-class encoding
    case ({r_x[0], r_y[0]})
      2'b00:   w_color = 2'd0;
      2'b11:   w_color = 2'd1;
      2'b10:   w_color = 2'd2;
      default: w_color = 2'd3;
    endcase
  end

  // Raster counters: the last pixel is held through DRAIN/DONE so no address leaves the frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_launch) begin
      r_x <= '0;
      r_y <= '0;
    end else if ((r_state == S_RUN) && !w_stall && !w_last_issue) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Write-address delay line; bubbles carry the held address so the tail stays in range
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        r_vld_p[i] <= 1'b0;
        r_x_p[i]   <= '0;
        r_y_p[i]   <= '0;
      end
    end else if (w_advance) begin
      r_vld_p[0] <= (r_state == S_RUN);
      r_x_p[0]   <= r_x;
      r_y_p[0]   <= r_y;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_x_p[i]   <= r_x_p[i-1];
        r_y_p[i]   <= r_y_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= (r_state == S_DRAIN) && w_last_write;
  end

  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.issue_valid = w_issue_valid;
  assign bus.addr_x      = r_x;
  assign bus.addr_y      = r_y;
  assign bus.lateral     = w_lateral;
  assign bus.vertical    = w_vertical;
  assign bus.color       = w_color;
  assign bus.wr_en       = w_wr_en;
  assign bus.wr_x        = r_x_p[PIPE_LATENCY-1];
  assign bus.wr_y        = r_y_p[PIPE_LATENCY-1];

endmodule

// File: tb/tb_demosaic_scan_ctrl.sv
// Directed bench for demosaic_scan_ctrl: three instances (40x30 lat 1, 40x30 lat 3, 4x2 lat 1)
// exercised one at a time through a shared observation mux.
module tb_demosaic_scan_ctrl;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   sel;
  int   checks;
  int   failures;

  demosaic_scan_ctrl_if #(.XW(6), .YW(5)) ia ();
  demosaic_scan_ctrl_if #(.XW(6), .YW(5)) ib ();
  demosaic_scan_ctrl_if #(.XW(6), .YW(5)) ic ();

  demosaic_scan_ctrl #(.WIDTH(40), .HEIGHT(30), .PIPE_LATENCY(1), .XW(6), .YW(5))
    u_a (.clk(clk), .reset(rst_a), .bus(ia.master));
  demosaic_scan_ctrl #(.WIDTH(40), .HEIGHT(30), .PIPE_LATENCY(3), .XW(6), .YW(5))
    u_b (.clk(clk), .reset(rst_b), .bus(ib.master));
  demosaic_scan_ctrl #(.WIDTH(4), .HEIGHT(2), .PIPE_LATENCY(1), .XW(6), .YW(5))
    u_c (.clk(clk), .reset(rst_c), .bus(ic.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mon_a, mon_b, mon_c, mon;
  logic        o_busy, o_done, o_issue_valid, o_wr_en;
  logic [5:0]  o_addr_x, o_wr_x;
  logic [4:0]  o_addr_y, o_wr_y;
  logic [1:0]  o_lateral, o_vertical, o_color;

  assign mon_a = {ia.busy, ia.done, ia.issue_valid, ia.addr_x, ia.addr_y, ia.lateral,
                  ia.vertical, ia.color, ia.wr_en, ia.wr_x, ia.wr_y};
  assign mon_b = {ib.busy, ib.done, ib.issue_valid, ib.addr_x, ib.addr_y, ib.lateral,
                  ib.vertical, ib.color, ib.wr_en, ib.wr_x, ib.wr_y};
  assign mon_c = {ic.busy, ic.done, ic.issue_valid, ic.addr_x, ic.addr_y, ic.lateral,
                  ic.vertical, ic.color, ic.wr_en, ic.wr_x, ic.wr_y};
  assign mon   = (sel == 1) ? mon_b : ((sel == 2) ? mon_c : mon_a);
  assign {o_busy, o_done, o_issue_valid, o_addr_x, o_addr_y, o_lateral,
          o_vertical, o_color, o_wr_en, o_wr_x, o_wr_y} = mon;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drv_start(input logic v);
    case (sel)
      1:       ib.start = v;
      2:       ic.start = v;
      default: ia.start = v;
    endcase
  endtask

  task automatic drv_ready(input logic v);
    case (sel)
      1:       ib.out_ready = v;
      2:       ic.out_ready = v;
      default: ia.out_ready = v;
    endcase
  endtask

  // One full frame on the selected instance with optional stall injection and start spamming
  task automatic run_frame(input int w, input int h, input int lat,
                           input bit stall_en, input bit spam);
    int busy_cnt, nwr, order_err, first_wr, last_wr, done_cnt, done_c, ex, ey, stall_cnt;
    int v01;
    bit stall_used, released;
    busy_cnt = 0; nwr = 0; order_err = 0; first_wr = -1; last_wr = -1;
    done_cnt = 0; done_c = -1; ex = 0; ey = 0; stall_cnt = 0;
    stall_used = 0; released = 0;
    v01 = (h == 2) ? 2 : 1;
    drv_ready(1'b1);
    drv_start(1'b1);
    @(posedge clk); #1;
    drv_start(1'b0);
    for (int c = 0; c < w * h + lat + 40; c++) begin
      if (stall_cnt == 1) begin
        drv_ready(1'b1); stall_cnt = 0; released = 1;
      end else if (stall_cnt > 1) begin
        stall_cnt--;
      end else if (stall_en && !stall_used && o_wr_en && o_wr_x == 5 && o_wr_y == 2) begin
        drv_ready(1'b0); stall_used = 1; stall_cnt = 3;
      end
      drv_start(spam && o_issue_valid && (c % 5 == 2));
      #1;
      if (c == 0) begin
        chk("first_issue_valid", o_issue_valid, 1);
        chk("first_busy", o_busy, 1);
        chk("first_addr_x", o_addr_x, 0);
        chk("first_addr_y", o_addr_y, 0);
        chk("first_lateral", o_lateral, 0);
        chk("first_vertical", o_vertical, 0);
        chk("first_color", o_color, 0);
      end
      if (stall_cnt > 0) begin
        chk("stall_wr_en", o_wr_en, 0);
        chk("stall_addr_x", o_addr_x, 6);
        chk("stall_addr_y", o_addr_y, 2);
        chk("stall_issue_valid", o_issue_valid, 1);
      end
      if (released) begin
        chk("release_wr_en", o_wr_en, 1);
        chk("release_wr_x", o_wr_x, 5);
        chk("release_wr_y", o_wr_y, 2);
        released = 0;
      end
      if (o_busy) busy_cnt++;
      if (o_issue_valid) begin
        if (o_addr_x == w - 1 && o_addr_y == 0) begin
          chk("top_right_lateral", o_lateral, 2);
          chk("top_right_vertical", o_vertical, 0);
          chk("top_right_color", o_color, 2);
        end
        if (o_addr_x == 0 && o_addr_y == 1) begin
          chk("row1_left_lateral", o_lateral, 0);
          chk("row1_left_vertical", o_vertical, v01);
          chk("row1_left_color", o_color, 3);
        end
        if (o_addr_x == w - 1 && o_addr_y == h - 1) begin
          chk("last_lateral", o_lateral, 2);
          chk("last_vertical", o_vertical, 2);
          chk("last_color", o_color, 1);
        end
      end
      if (o_wr_en) begin
        if (o_wr_x != ex || o_wr_y != ey) order_err++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        nwr++;
        if (ex == w - 1) begin ex = 0; ey++; end
        else ex++;
      end
      if (o_done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 3) break;
      @(posedge clk); #1;
    end
    drv_start(1'b0);
    drv_ready(1'b1);
    chk("write_count", nwr, w * h);
    chk("raster_order_errors", order_err, 0);
    chk("issue_to_write_latency", first_wr, lat);
    chk("busy_cycles", busy_cnt, w * h + lat + (stall_en ? 3 : 0));
    chk("done_pulses", done_cnt, 1);
    chk("done_after_last_write", done_c - last_wr, 1);
    chk("done_state_busy", o_busy, 0);
    chk("done_state_issue_valid", o_issue_valid, 0);
    chk("done_state_wr_en", o_wr_en, 0);
    chk("done_state_addr_x", o_addr_x, w - 1);
    chk("done_state_addr_y", o_addr_y, h - 1);
  endtask

  initial begin
    int found, nwr;
    checks = 0; failures = 0; sel = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
    ia.out_ready = 1'b1; ib.out_ready = 1'b1; ic.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_issue_valid", o_issue_valid, 0);
    chk("rst_addr_x", o_addr_x, 0);
    chk("rst_addr_y", o_addr_y, 0);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_wr_x", o_wr_x, 0);
    chk("rst_wr_y", o_wr_y, 0);
    chk("rst_lateral", o_lateral, 0);
    chk("rst_vertical", o_vertical, 0);
    chk("rst_color", o_color, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", o_busy, 0);

    // Default frame, then a stalled frame, then a frame with start spammed during RUN
    run_frame(40, 30, 1, 1'b0, 1'b0);
    run_frame(40, 30, 1, 1'b1, 1'b0);
    run_frame(40, 30, 1, 1'b0, 1'b1);

    // Reset in the middle of a frame
    drv_start(1'b1);
    @(posedge clk); #1;
    drv_start(1'b0);
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      if (o_issue_valid && o_addr_x == 17 && o_addr_y == 12) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("midrst_reached_17_12", found, 1);
    rst_a = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    chk("midrst_issue_valid", o_issue_valid, 0);
    chk("midrst_addr_x", o_addr_x, 0);
    chk("midrst_addr_y", o_addr_y, 0);
    chk("midrst_wr_en", o_wr_en, 0);
    chk("midrst_wr_x", o_wr_x, 0);
    chk("midrst_wr_y", o_wr_y, 0);
    chk("midrst_lateral", o_lateral, 0);
    chk("midrst_vertical", o_vertical, 0);
    chk("midrst_color", o_color, 0);
    rst_a = 1'b0;
    nwr = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (o_wr_en) nwr++;
    end
    chk("midrst_no_writes", nwr, 0);
    chk("midrst_idle_busy", o_busy, 0);
    run_frame(40, 30, 1, 1'b0, 1'b0);

    sel = 1;
    #1;
    chk("lat3_idle_busy", o_busy, 0);
    run_frame(40, 30, 3, 1'b0, 1'b0);

    sel = 2;
    #1;
    chk("small_idle_busy", o_busy, 0);
    run_frame(4, 2, 1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demosaic_scan_ctrl.md
Name: demosaic_scan_ctrl

Overview:
- Frame sequencer for the Bayer 3x3 demosaic datapath. On `start` it raster-scans the WIDTH x HEIGHT input image and drives, for each pixel, the read address plus the lateral/vertical edge class and Bayer colour class into the filter.
- It delay-matches the write address through PIPE_LATENCY stages to the RGBA output store. It applies downstream backpressure with a global stall and reports busy/done.
- It replaces the free-running pixel counter in the top level.

Parameters:
- WIDTH, 40, pixels per row (>=2)
- HEIGHT, 30, rows per frame (>=2)
- PIPE_LATENCY, 1, cycles from issued address to valid filter result (>=1)
- XW, 6, x address width (>= clog2(WIDTH))
- YW, 5, y address width (>= clog2(HEIGHT))

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin frame; sampled in IDLE or DONE only
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the last pixel is written
- issue_valid  out  1  addr/class outputs are valid this cycle
- addr_x  out  XW  column of centre pixel
- addr_y  out  YW  row of centre pixel
- lateral  out  2  0 Left (x==0), 1 Center, 2 Right (x==WIDTH-1)
- vertical  out  2  0 Top (y==0), 1 Middle, 2 Bottom (y==HEIGHT-1)
- color  out  2  {x[0],y[0]}: 00 Red=0, 11 Blue=1, 10 GreenBesideRed=2, 01 GreenBesideBlue=3
- out_ready  in  1  output store can accept a write
- wr_en  out  1  write filter result this cycle
- wr_x  out  XW  write column
- wr_y  out  YW  write row

Behaviour:
- States: IDLE, RUN, DRAIN, DONE. Reset forces IDLE from any state, including mid-frame. Reset clears the pipeline and sets all outputs to 0: busy, done, issue_valid, addr, wr_en, wr_x/y. Class outputs decode to lateral=0, vertical=0, color=0.
- IDLE/DONE to RUN on start=1. addr_x and addr_y load 0 on that edge; issue_valid=1 from the next cycle.
- stall = pipeline-tail-valid & ~out_ready. While stall=1:
  - addresses hold;
  - all pipeline stages hold;
  - issue_valid stays asserted with unchanged values.
- RUN, no stall: each cycle push (valid=1, addr_x, addr_y) into stage 0 and advance the raster.
  - x increments; at x==WIDTH-1, x wraps to 0 and y increments.
  - At (WIDTH-1, HEIGHT-1), go to DRAIN after the push. issue_valid=0 in DRAIN.
- DRAIN: push valid=0 bubbles. When the last valid entry is written (wr_en with wr_x==WIDTH-1, wr_y==HEIGHT-1), go to DONE and pulse done for exactly 1 cycle.
- DONE: busy=0. Outputs hold their last values, issue_valid=0. start re-launches a frame.
- start in RUN/DRAIN is ignored.
- Pipeline: PIPE_LATENCY-deep shift register of {valid,x,y}. The tail drives wr_x/wr_y. wr_en = tail.valid & out_ready.
- Latency: a pixel issued in cycle t is written in cycle t+PIPE_LATENCY when no stalls occur.
- Class outputs are pure combinational decodes of the current addr_x/addr_y.
- Frame without stalls: busy high for WIDTH*HEIGHT+PIPE_LATENCY cycles. Exactly WIDTH*HEIGHT wr_en pulses, each (x,y) once, in raster order.
- Counters never exceed WIDTH-1 / HEIGHT-1. No out-of-range address is ever presented, even in DRAIN.

Test Plan:
- Reset, start at cycle 5, out_ready=1, defaults:
  - first issue (0,0) with lateral=0, vertical=0, color=0;
  - (39,0) gives lateral=2, color=2;
  - (0,1) gives color=3;
  - (39,29) gives lateral=2, vertical=2, color=1;
  - 1200 wr_en pulses in raster order, done pulses one cycle after the write of (39,29), busy high 1201 cycles.
- out_ready low for 3 cycles while tail holds (5,2):
  - wr_en=0 for those cycles; addr holds at (6,2) with PIPE_LATENCY=1;
  - on release, (5,2) is written next, then (6,2); no pixel is lost or duplicated.
- PIPE_LATENCY=3: pixel issued at cycle t is written at t+3; total busy 1203 cycles.
- Reset asserted while addr=(17,12) in RUN:
  - next cycle state IDLE, all outputs 0, no further wr_en;
  - a new start rescans from (0,0).
- start pulsed repeatedly during RUN: no restart, exactly 1200 writes. A start after DONE runs a second full frame.
- WIDTH=4, HEIGHT=2: raster (0,0)..(3,0),(0,1)..(3,1); x wraps at 3; Right class at x=3; Bottom class on row 1; done after 8 writes.
